// File: rtl/led_fade_pkg.sv
// Shared definitions for the LED fade controller: channel state encoding,
// datapath widths and the single-step brightness helper.
package led_fade_pkg;

    localparam int BRIGHT_W = 8;
    localparam int RATE_W   = 8;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RAMP = 1'b1;

    // One unsigned step toward tgt; equal inputs hold, so the result never wraps.
    function automatic logic [BRIGHT_W-1:0] step_toward(
        input logic [BRIGHT_W-1:0] cur,
        input logic [BRIGHT_W-1:0] tgt
    );
        if (cur < tgt) begin
            return cur + BRIGHT_W'(1);
        end else if (cur > tgt) begin
            return cur - BRIGHT_W'(1);
        end else begin
            return cur;
        end
    endfunction

endpackage

// File: rtl/led_fade_channel.sv
// One LED channel: holds brightness, ramps one step per `rate` fade ticks
// toward the commanded target, and pulses done on arrival.
module led_fade_channel
    import led_fade_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    input  logic                cmd_hit,
    input  logic [BRIGHT_W-1:0] cmd_target,
    input  logic [RATE_W-1:0]   cmd_rate,
    output logic [BRIGHT_W-1:0] bright,
    output logic                busy,
    output logic                done
);

    logic [0:0]          state;
    logic [BRIGHT_W-1:0] target;
    logic [RATE_W-1:0]   rate;
    logic [RATE_W-1:0]   rate_cnt;
    logic [BRIGHT_W-1:0] next_bright;

    assign next_bright = step_toward(bright, target);
    assign busy        = (state == ST_RAMP);

    // Channel state machine; a command always wins over a coincident tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            target   <= '0;
            rate     <= '0;
            rate_cnt <= '0;
            bright   <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (cmd_hit) begin
                target   <= cmd_target;
                rate     <= cmd_rate;
                rate_cnt <= '0;
                if ((cmd_rate == '0) || (cmd_target == bright)) begin
                    // Immediate: jump straight to the target and report arrival.
                    bright <= cmd_target;
                    state  <= ST_IDLE;
                    done   <= 1'b1;
                end else begin
                    // Ramp (or retarget) from wherever brightness is now.
                    state <= ST_RAMP;
                end
            end else if ((state == ST_RAMP) && tick) begin
                if (rate_cnt == rate - RATE_W'(1)) begin
                    rate_cnt <= '0;
                    bright   <= next_bright;
                    if (next_bright == target) begin
                        state <= ST_IDLE;
                        done  <= 1'b1;
                    end
                end else begin
                    rate_cnt <= rate_cnt + RATE_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/led_fade_ctrl.sv
// LED fade controller: free-running fade-tick prescaler, command decode and
// NCH independent fading channels.
module led_fade_ctrl
    import led_fade_pkg::*;
#(
    parameter int NCH      = 4,
    parameter int PRESCALE = 256,
    localparam int CHW     = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int PSW     = $clog2(PRESCALE)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [CHW-1:0]          cmd_ch,
    input  logic [BRIGHT_W-1:0]     cmd_target,
    input  logic [RATE_W-1:0]       cmd_rate,
    output logic [BRIGHT_W*NCH-1:0] bright,
    output logic [NCH-1:0]          busy,
    output logic [NCH-1:0]          done
);

    logic [PSW-1:0] pcnt;
    logic           tick;
    logic           cmd_fire;

    assign tick     = (pcnt == PSW'(PRESCALE - 1));
    assign cmd_fire = cmd_valid && cmd_ready;

    // Prescaler counts 0..PRESCALE-1 regardless of command traffic.
    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt <= '0;
        end else if (tick) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + PSW'(1);
        end
    end

    // Commands are never back-pressured; ready drops only while in reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_ready <= 1'b0;
        end else begin
            cmd_ready <= 1'b1;
        end
    end

    // Out-of-range channel indices match no instance and are dropped.
    for (genvar k = 0; k < NCH; k++) begin : g_ch
        led_fade_channel u_ch (
            .clk        (clk),
            .rst        (rst),
            .tick       (tick),
            .cmd_hit    (cmd_fire && (cmd_ch == CHW'(k))),
            .cmd_target (cmd_target),
            .cmd_rate   (cmd_rate),
            .bright     (bright[BRIGHT_W*k +: BRIGHT_W]),
            .busy       (busy[k]),
            .done       (done[k])
        );
    end

endmodule

// File: tb/tb_led_fade_ctrl.sv
// Directed bench for led_fade_ctrl with PRESCALE=4: a 4-channel instance for
// the main behaviour and a 3-channel instance for the out-of-range index case.
module tb_led_fade_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_ch = '0;
    logic [7:0]  cmd_target = '0;
    logic [7:0]  cmd_rate = '0;
    logic [31:0] bright;
    logic [3:0]  busy;
    logic [3:0]  done;

    logic        c3_valid = 1'b0;
    logic        c3_ready;
    logic [1:0]  c3_ch = '0;
    logic [7:0]  c3_target = '0;
    logic [7:0]  c3_rate = '0;
    logic [23:0] b3;
    logic [2:0]  busy3;
    logic [2:0]  done3;

    int n_cmp  = 0;
    int n_fail = 0;
    int ecnt   = 0;

    always #5 clk = ~clk;

    // Edges since reset release; edge number n is a tick edge when n%4==0.
    always @(posedge clk) begin
        if (rst) ecnt <= 0;
        else     ecnt <= ecnt + 1;
    end

    led_fade_ctrl #(.NCH(4), .PRESCALE(4)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ch(cmd_ch), .cmd_target(cmd_target), .cmd_rate(cmd_rate),
        .bright(bright), .busy(busy), .done(done)
    );

    led_fade_ctrl #(.NCH(3), .PRESCALE(4)) dut3 (
        .clk(clk), .rst(rst), .cmd_valid(c3_valid), .cmd_ready(c3_ready),
        .cmd_ch(c3_ch), .cmd_target(c3_target), .cmd_rate(c3_rate),
        .bright(b3), .busy(busy3), .done(done3)
    );

    typedef struct {
        int         ch;
        logic [7:0] tgt;
        logic [7:0] rate;
        logic [3:0] exp_busy;
        logic [3:0] exp_done;
        logic [7:0] exp_b;
    } vec_t;

    vec_t       vecs[9];
    logic [7:0] mb[4];

    function automatic logic [7:0] br(input int k);
        return bright[8*k +: 8];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called at a negedge; returns at the negedge right after the accepting edge.
    task automatic send(input int ch, input logic [7:0] tgt, input logic [7:0] rate);
        cmd_valid  = 1'b1;
        cmd_ch     = 2'(ch);
        cmd_target = tgt;
        cmd_rate   = rate;
        @(negedge clk);
        cmd_valid  = 1'b0;
    endtask

    // Wait at negedges until the coming posedge is a prescaler tick edge.
    task automatic align_tick();
        for (int i = 0; i < 8; i++) begin
            if ((ecnt + 1) % 4 == 0) break;
            @(negedge clk);
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] eb;
        int          seen, dcnt, ups, jumps;
        logic [7:0]  prev;

        vecs[0] = '{1, 8'd200, 8'd0,   4'b0000, 4'b0010, 8'd200};
        vecs[1] = '{0, 8'd0,   8'd7,   4'b0000, 4'b0001, 8'd0};
        vecs[2] = '{2, 8'd255, 8'd0,   4'b0000, 4'b0100, 8'd255};
        vecs[3] = '{3, 8'd50,  8'd255, 4'b1000, 4'b0000, 8'd0};
        vecs[4] = '{3, 8'd77,  8'd0,   4'b0000, 4'b1000, 8'd77};
        vecs[5] = '{2, 8'd255, 8'd9,   4'b0000, 4'b0100, 8'd255};
        vecs[6] = '{1, 8'd0,   8'd0,   4'b0000, 4'b0010, 8'd0};
        vecs[7] = '{1, 8'd1,   8'd3,   4'b0010, 4'b0000, 8'd0};
        vecs[8] = '{1, 8'd1,   8'd0,   4'b0000, 4'b0010, 8'd1};

        // Reset held three cycles
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_bright", bright, 32'd0);
            chk("rst_busy", {28'd0, busy}, 32'd0);
            chk("rst_done", {28'd0, done}, 32'd0);
            chk("rst_ready", {31'd0, cmd_ready}, 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_release", {31'd0, cmd_ready}, 32'd1);

        // Table of commands, each checked one cycle and two cycles after acceptance
        for (int k = 0; k < 4; k++) mb[k] = 8'd0;
        for (int v = 0; v < 9; v++) begin
            send(vecs[v].ch, vecs[v].tgt, vecs[v].rate);
            mb[vecs[v].ch] = vecs[v].exp_b;
            for (int k = 0; k < 4; k++) eb[8*k +: 8] = mb[k];
            chk($sformatf("vec%0d_bright", v), bright, eb);
            chk($sformatf("vec%0d_busy", v), {28'd0, busy}, {28'd0, vecs[v].exp_busy});
            chk($sformatf("vec%0d_done", v), {28'd0, done}, {28'd0, vecs[v].exp_done});
            @(negedge clk);
            chk($sformatf("vec%0d_done_clear", v), {28'd0, done}, 32'd0);
        end

        // Ramp up ch0 0->5 rate 2, accepted on a tick edge
        do_reset(2);
        align_tick();
        send(0, 8'd5, 8'd2);
        chk("ramp_start_bright", {24'd0, br(0)}, 32'd0);
        chk("ramp_start_busy", {31'd0, busy[0]}, 32'd1);
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            chk($sformatf("ramp_b_k%0d", k), {24'd0, br(0)}, (k / 8 < 5) ? 32'(k / 8) : 32'd5);
            chk($sformatf("ramp_busy_k%0d", k), {31'd0, busy[0]}, (k < 40) ? 32'd1 : 32'd0);
            chk($sformatf("ramp_done_k%0d", k), {31'd0, done[0]}, (k == 40) ? 32'd1 : 32'd0);
        end

        // Retarget ch2 mid-ramp from 10 down to 3
        do_reset(2);
        send(2, 8'd100, 8'd1);
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            if (br(2) == 8'd10) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        chk("retgt_reached_10", 32'(seen), 32'd1);
        send(2, 8'd3, 8'd1);
        chk("retgt_hold_10", {24'd0, br(2)}, 32'd10);
        chk("retgt_busy", {31'd0, busy[2]}, 32'd1);
        dcnt = 0; ups = 0; jumps = 0; prev = br(2);
        for (int i = 0; i < 420; i++) begin
            @(negedge clk);
            if (done[2]) begin
                dcnt++;
                chk("retgt_done_at_3", {24'd0, br(2)}, 32'd3);
            end
            if (br(2) > prev) ups++;
            if (prev - br(2) > 8'd1 && br(2) < prev) jumps++;
            prev = br(2);
        end
        chk("retgt_done_count", 32'(dcnt), 32'd1);
        chk("retgt_final", {24'd0, br(2)}, 32'd3);
        chk("retgt_idle", {31'd0, busy[2]}, 32'd0);
        chk("retgt_no_up", 32'(ups), 32'd0);
        chk("retgt_no_jump", 32'(jumps), 32'd0);

        // Command/tick collision: ch3 immediate and ch0 step on the same edge
        do_reset(2);
        align_tick();
        send(0, 8'd2, 8'd1);
        align_tick();
        send(3, 8'd9, 8'd0);
        chk("coll_ch0_step", {24'd0, br(0)}, 32'd1);
        chk("coll_ch3", {24'd0, br(3)}, 32'd9);
        chk("coll_done", {28'd0, done}, 32'b1000);
        chk("coll_busy", {28'd0, busy}, 32'b0001);
        // Command to ch0 on a tick edge suppresses that tick for ch0
        align_tick();
        send(0, 8'd2, 8'd1);
        chk("coll_ch0_noskip", {24'd0, br(0)}, 32'd1);
        chk("coll_ch0_busy", {31'd0, busy[0]}, 32'd1);
        chk("coll_ch0_nodone", {28'd0, done}, 32'd0);
        align_tick();
        @(negedge clk);
        chk("coll_ch0_final", {24'd0, br(0)}, 32'd2);
        chk("coll_ch0_done", {28'd0, done}, 32'b0001);
        chk("coll_ch0_idle", {28'd0, busy}, 32'd0);

        // Out-of-range channel on the 3-channel instance
        c3_valid = 1'b1; c3_ch = 2'd3; c3_target = 8'd200; c3_rate = 8'd0;
        @(negedge clk);
        c3_valid = 1'b0;
        chk("oor_bright", {8'd0, b3}, 32'd0);
        chk("oor_done", {29'd0, done3}, 32'd0);
        c3_valid = 1'b1; c3_ch = 2'd3; c3_rate = 8'd5;
        @(negedge clk);
        c3_valid = 1'b0;
        chk("oor_busy", {29'd0, busy3}, 32'd0);
        c3_valid = 1'b1; c3_ch = 2'd2; c3_rate = 8'd0;
        @(negedge clk);
        c3_valid = 1'b0;
        chk("inrange_bright", {8'd0, b3}, 32'h00C80000);
        chk("inrange_done", {29'd0, done3}, 32'b100);

        // Reset during a ramp, with a command held through reset
        do_reset(2);
        send(0, 8'd255, 8'd1);
        repeat (20) @(negedge clk);
        chk("midrst_ramping", {31'd0, busy[0]}, 32'd1);
        rst = 1'b1;
        cmd_valid = 1'b1; cmd_ch = 2'd1; cmd_target = 8'd99; cmd_rate = 8'd0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("midrst_bright", bright, 32'd0);
            chk("midrst_busy", {28'd0, busy}, 32'd0);
            chk("midrst_done", {28'd0, done}, 32'd0);
            chk("midrst_ready", {31'd0, cmd_ready}, 32'd0);
        end
        rst = 1'b0;
        cmd_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("postrst_bright", bright, 32'd0);
            chk("postrst_done", {28'd0, done}, 32'd0);
            chk("postrst_busy", {28'd0, busy}, 32'd0);
        end
        chk("postrst_ready", {31'd0, cmd_ready}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/led_fade_ctrl.md
LED_FADE_CTRL -- requirements
Module: led_fade_ctrl

Interface
REQ-001 SHALL have parameter NCH, default 4, number of LED channels (1..16).
REQ-002 SHALL have parameter PRESCALE, default 256, clk cycles per fade tick (>=2).
REQ-003 SHALL have port clk  input  1  sole clock; all logic on posedge clk.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port cmd_valid  input  1  command strobe.
REQ-006 SHALL have port cmd_ready  output  1  command accept; a command is taken when cmd_valid&&cmd_ready at a clock edge.
REQ-007 SHALL have port cmd_ch  input  $clog2(NCH) (min 1)  target channel index.
REQ-008 SHALL have port cmd_target  input  8  target brightness 0..255.
REQ-009 SHALL have port cmd_rate  input  8  fade ticks per brightness step; 0 = immediate.
REQ-010 SHALL have port bright  output  8*NCH  per-channel brightness, channel k at bits [8k+7:8k], registered, fed to one PWM generator per channel.
REQ-011 SHALL have port busy  output  NCH  channel k ramping.
REQ-012 SHALL have port done  output  NCH  one-cycle pulse when channel k reaches its target.

Function
REQ-013 Prescaler SHALL count 0..PRESCALE-1 and wrap; tick is high for one cycle when count==PRESCALE-1; free-running, unaffected by commands.
REQ-014 cmd_ready SHALL be 1 in every cycle except while rst is high; commands are never back-pressured.
REQ-015 Each channel SHALL hold state IDLE or RAMP, plus registers target[7:0], rate[7:0], rate_cnt[7:0].
REQ-016 On accepted command with cmd_ch>=NCH: SHALL be ignored, no output change.
REQ-017 On accepted command to channel k with cmd_rate==0 or cmd_target==bright[k]: next edge SHALL set bright[k]=cmd_target, state IDLE, busy[k]=0, done[k]=1 for one cycle.
REQ-018 Otherwise on accepted command: next edge SHALL latch target/rate, clear rate_cnt, enter RAMP, busy[k]=1; bright[k] unchanged.
REQ-019 Command to a channel already in RAMP SHALL retarget from current bright[k] (no jump) and restart rate_cnt at 0; no done pulse for the abandoned target.
REQ-020 In RAMP, on tick: if rate_cnt==rate-1 SHALL clear rate_cnt and move bright[k] by exactly 1 toward target; else increment rate_cnt.
REQ-021 When the step makes bright[k]==target: same edge SHALL enter IDLE, busy[k]=0, done[k]=1 for exactly one cycle.
REQ-022 bright[k] SHALL never wrap; arithmetic is unsigned 8-bit and steps only toward target, so 0 and 255 are reachable endpoints, never crossed.
REQ-023 Command and tick in same cycle for channel k: command SHALL take priority, tick ignored for k; other channels process the tick normally.
REQ-024 Channels SHALL be independent; all may step on the same tick.
REQ-025 Timing: after acceptance at cycle 0, first step SHALL occur on the rate-th tick edge after acceptance; full ramp of D steps takes D*rate ticks.
REQ-026 In IDLE, ticks SHALL have no effect; bright[k] holds.

Reset
REQ-027 While rst=1 at an edge: bright=0, busy=0, done=0, all states IDLE, target/rate/rate_cnt=0, prescaler=0, cmd_ready=0.
REQ-028 Reset mid-ramp SHALL abort without done pulse; commands presented while rst=1 are discarded.

Structure
REQ-029 Shared package SHALL hold channel state encoding (IDLE, RAMP), brightness width constant (8) and rate width constant (8).
REQ-030 One sub-module led_fade_channel (one channel's state, counters, bright, busy, done) SHALL be instantiated NCH times by generate; prescaler and command decode stay in led_fade_ctrl.

Verification (bench PRESCALE=4, NCH=4)
REQ-031 Reset: hold rst 3 cycles -> bright=0, busy=0, done=0, cmd_ready=0; release -> cmd_ready=1 next cycle.
REQ-032 Immediate: ch1 target=200 rate=0 -> bright[1]=200 and done[1] pulse one cycle later, busy[1] never high.
REQ-033 Ramp up: ch0 0->5 rate=2 -> bright[0] steps +1 every 8 cycles, reaches 5 after 40 cycles, done[0] pulse coincident, busy[0] falls.
REQ-034 Retarget: ch2 ramping 0->100 rate=1, at bright=10 command target=3 rate=1 -> bright counts down 10..3, single done pulse, none for 100.
REQ-035 Collision/bounds: command to ch3 aligned with tick while ch0 ramps -> ch0 steps, ch3 takes command; cmd_ch=5 (NCH=4 with width 2 not reachable, use NCH=3 run, cmd_ch=3) -> no change.
REQ-036 Reset mid-ramp: rst during ch0 ramp 0->255 rate=1 -> bright[0]=0, busy=0, no done pulse.
